// File: rtl/testcore_nios2_gen2_0_ocimem_master.sv
// OCI memory master: turns JTAG debug commands (address/read, read-next,
// write) into single Avalon-MM transfers and reports the outcome through
// MonDReg / monitor_ready / monitor_error. Stalled transfers are aborted
// after TIMEOUT_CYCLES cycles of m_waitrequest.
module testcore_nios2_gen2_0_ocimem_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Last wait-counter value tolerated before the transfer is abandoned.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        incr_en_reg;
    logic [15:0] wait_cnt_reg;
    logic        m_read_reg;
    logic        m_write_reg;
    logic [31:0] mon_d_reg;
    logic        ready_reg;
    logic        error_reg;

    logic        any_cmd;

    // jdo[37] and jdo[33:32] carry nothing for this block.
    logic        unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[37], jdo[33:32]};

    assign any_cmd = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    // Command decode, bus sequencing, timeout and monitor status in one FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            incr_en_reg  <= 1'b0;
            wait_cnt_reg <= 16'h0;
            m_read_reg   <= 1'b0;
            m_write_reg  <= 1'b0;
            mon_d_reg    <= 32'h0;
            ready_reg    <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Priority: address command, then write, then read-next.
                    if (take_action_ocimem_a) begin
                        addr_reg    <= {jdo[31:2], 2'b00};
                        incr_en_reg <= jdo[36];
                        if (jdo[34]) begin
                            error_reg <= 1'b0;
                        end
                        if (jdo[35]) begin
                            state_reg    <= READ;
                            m_read_reg   <= 1'b1;
                            ready_reg    <= 1'b0;
                            wait_cnt_reg <= 16'h0;
                        end
                    end else if (take_action_ocimem_b) begin
                        wdata_reg    <= jdo[31:0];
                        mon_d_reg    <= jdo[31:0];
                        state_reg    <= WRITE;
                        m_write_reg  <= 1'b1;
                        ready_reg    <= 1'b0;
                        wait_cnt_reg <= 16'h0;
                    end else if (take_no_action_ocimem_a) begin
                        state_reg    <= READ;
                        m_read_reg   <= 1'b1;
                        ready_reg    <= 1'b0;
                        wait_cnt_reg <= 16'h0;
                    end
                end
                READ, WRITE: begin
                    // Commands cannot be queued while a transfer is in flight.
                    if (any_cmd) begin
                        error_reg <= 1'b1;
                    end
                    if (!m_waitrequest) begin
                        if (state_reg == READ) begin
                            mon_d_reg <= m_readdata;
                        end
                        if (incr_en_reg) begin
                            addr_reg <= addr_reg + 32'd4;
                        end
                        ready_reg   <= 1'b1;
                        state_reg   <= IDLE;
                        m_read_reg  <= 1'b0;
                        m_write_reg <= 1'b0;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        error_reg   <= 1'b1;
                        ready_reg   <= 1'b1;
                        state_reg   <= IDLE;
                        m_read_reg  <= 1'b0;
                        m_write_reg <= 1'b0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    m_read_reg  <= 1'b0;
                    m_write_reg <= 1'b0;
                end
            endcase
        end
    end

    assign m_read        = m_read_reg;
    assign m_write       = m_write_reg;
    assign m_address     = addr_reg;
    assign m_writedata   = wdata_reg;
    assign m_byteenable  = 4'hF;
    assign MonDReg       = mon_d_reg;
    assign monitor_ready = ready_reg;
    assign monitor_error = error_reg;

endmodule

// File: tb/tb_testcore_nios2_gen2_0_ocimem_master.sv
// Bench for the OCI memory master: a table of debug commands, a stalling
// Avalon slave model with a scoreboard of expected transfers, and hand
// sequences for collisions, simultaneous pulses and mid-transfer reset.
module tb_testcore_nios2_gen2_0_ocimem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic [31:0] m_readdata;
    logic        m_waitrequest;

    testcore_nios2_gen2_0_ocimem_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .m_address               (m_address),
        .m_read                  (m_read),
        .m_write                 (m_write),
        .m_writedata             (m_writedata),
        .m_byteenable            (m_byteenable),
        .m_readdata              (m_readdata),
        .m_waitrequest           (m_waitrequest)
    );

    always #5 clk = ~clk;

    localparam int K_ADDR = 0;  // take_action_ocimem_a
    localparam int K_WR   = 1;  // take_action_ocimem_b
    localparam int K_RD   = 2;  // take_no_action_ocimem_a

    typedef struct {
        int          kind;
        logic [37:0] jdo;
        int          stall;     // -1: never release waitrequest
        logic [31:0] rdata;
        logic        xfer;      // a completed transfer is expected
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        int          exp_high;  // cycles with m_read|m_write high
        logic [31:0] exp_mon;
        logic        exp_ready;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    sb_t  sb_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   stall_cfg = 0;
    logic [31:0] rdata_cfg = 32'h0;
    int   busy_cnt = 0;
    int   high_cnt = 0;
    int   wr_high_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [37:0] mkj(input logic incr, input logic rd, input logic clr,
                                        input logic [31:0] d);
        return {1'b0, incr, rd, clr, 2'b00, d};
    endfunction

    // Avalon slave model: stalls stall_cfg cycles per transfer, then
    // completes and checks the transfer against the scoreboard.
    always @(negedge clk) begin
        m_readdata = rdata_cfg;
        if (m_read || m_write) begin
            high_cnt++;
            if (m_write) wr_high_cnt++;
            check("rw_exclusive", {31'h0, m_read & m_write}, 32'h0);
            if (stall_cfg < 0 || busy_cnt < stall_cfg) begin
                m_waitrequest = 1'b1;
                busy_cnt++;
            end else begin
                m_waitrequest = 1'b0;
                busy_cnt = 0;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_xfer", 32'h1, 32'h0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("sb_we", {31'h0, m_write}, {31'h0, e.we});
                    check("sb_addr", m_address, e.addr);
                    check("sb_byteenable", {28'h0, m_byteenable}, 32'hF);
                    if (e.we) check("sb_wdata", m_writedata, e.data);
                    $display("xfer %s addr=%h data=%h", e.we ? "WR" : "RD", m_address,
                             e.we ? m_writedata : rdata_cfg);
                end
            end
        end else begin
            m_waitrequest = 1'b0;
            busy_cnt = 0;
        end
    end

    // One-cycle command pulse, set and cleared on falling edges.
    task automatic pulse(input int kind, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = (kind == K_ADDR);
        take_action_ocimem_b    = (kind == K_WR);
        take_no_action_ocimem_a = (kind == K_RD);
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(monitor_ready && !m_read && !m_write) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("wait_idle_budget", 32'h1, 32'h0);
    endtask

    vec_t vecs[9];

    initial begin
        sb_t e;
        vecs[0] = '{K_ADDR, mkj(0,1,0,32'h0000_1004), 3, 32'hDEAD_BEEF, 1, 0, 32'h0000_1004, 32'h0, 4, 32'hDEAD_BEEF, 1, 0};
        vecs[1] = '{K_ADDR, mkj(1,0,0,32'hFFFF_FFFC), 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'hDEAD_BEEF, 1, 0};
        vecs[2] = '{K_WR,   mkj(0,0,0,32'h0000_0011), 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'h11, 1, 32'h11, 1, 0};
        vecs[3] = '{K_WR,   mkj(0,0,0,32'h0000_0022), 0, 32'h0, 1, 1, 32'h0000_0000, 32'h22, 1, 32'h22, 1, 0};
        vecs[4] = '{K_RD,   38'h0, 1, 32'h1234_5678, 1, 0, 32'h0000_0004, 32'h0, 2, 32'h1234_5678, 1, 0};
        vecs[5] = '{K_RD,   38'h0, -1, 32'h5555_5555, 0, 0, 32'h0, 32'h0, 8, 32'h1234_5678, 1, 1};
        vecs[6] = '{K_ADDR, mkj(0,0,1,32'h0000_0100), 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h1234_5678, 1, 0};
        vecs[7] = '{K_RD,   38'h0, 2, 32'hCAFE_F00D, 1, 0, 32'h0000_0100, 32'h0, 3, 32'hCAFE_F00D, 1, 0};
        vecs[8] = '{K_WR,   mkj(0,0,0,32'h0000_55AA), 0, 32'h0, 1, 1, 32'h0000_0100, 32'h55AA, 1, 32'h55AA, 1, 0};

        reset = 1'b1;
        jdo = 38'h0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        m_readdata = 32'h0;
        m_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready", {31'h0, monitor_ready}, 32'h0);
        check("rst_error", {31'h0, monitor_error}, 32'h0);
        check("rst_rw", {30'h0, m_read, m_write}, 32'h0);
        check("rst_address", m_address, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            stall_cfg = vecs[i].stall;
            rdata_cfg = vecs[i].rdata;
            high_cnt = 0;
            if (vecs[i].xfer) begin
                e.we = vecs[i].exp_we;
                e.addr = vecs[i].exp_addr;
                e.data = vecs[i].exp_data;
                sb_q.push_back(e);
            end
            pulse(vecs[i].kind, vecs[i].jdo);
            wait_idle();
            check($sformatf("v%0d_high", i), high_cnt, vecs[i].exp_high);
            check($sformatf("v%0d_mondreg", i), MonDReg, vecs[i].exp_mon);
            check($sformatf("v%0d_ready", i), {31'h0, monitor_ready}, {31'h0, vecs[i].exp_ready});
            check($sformatf("v%0d_error", i), {31'h0, monitor_error}, {31'h0, vecs[i].exp_err});
            $display("vec %0d kind=%0d mon=%h ready=%b err=%b high=%0d", i, vecs[i].kind,
                     MonDReg, monitor_ready, monitor_error, high_cnt);
        end

        // Write command arriving mid-read is dropped and flags an error.
        stall_cfg = 4;
        rdata_cfg = 32'hABCD_0123;
        high_cnt = 0;
        wr_high_cnt = 0;
        e.we = 1'b0; e.addr = 32'h100; e.data = 32'h0;
        sb_q.push_back(e);
        pulse(K_RD, 38'h0);
        @(negedge clk);
        pulse(K_WR, mkj(0,0,0,32'h0000_0BAD));
        wait_idle();
        check("busy_no_write", wr_high_cnt, 0);
        check("busy_mondreg", MonDReg, 32'hABCD_0123);
        check("busy_error", {31'h0, monitor_error}, 32'h1);
        $display("busy collision mon=%h err=%b", MonDReg, monitor_error);
        pulse(K_ADDR, mkj(0,0,1,32'h0000_0200));
        check("clr_error", {31'h0, monitor_error}, 32'h0);

        // Address command and write in the same cycle: write is dropped.
        high_cnt = 0;
        jdo = mkj(0,0,0,32'h0000_0300);
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        repeat (3) @(negedge clk);
        check("simul_high", high_cnt, 0);
        check("simul_ready", {31'h0, monitor_ready}, 32'h1);
        check("simul_mondreg", MonDReg, 32'hABCD_0123);
        stall_cfg = 0;
        rdata_cfg = 32'h0300_CAFE;
        e.we = 1'b0; e.addr = 32'h300; e.data = 32'h0;
        sb_q.push_back(e);
        pulse(K_RD, 38'h0);
        wait_idle();
        check("simul_read_mondreg", MonDReg, 32'h0300_CAFE);
        $display("simultaneous pulses then read mon=%h", MonDReg);

        // Reset during a stalled write.
        stall_cfg = -1;
        pulse(K_WR, mkj(0,0,0,32'h0000_0099));
        @(negedge clk);
        check("pre_rst_write", {31'h0, m_write}, 32'h1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_write", {31'h0, m_write}, 32'h0);
        check("async_rst_read", {31'h0, m_read}, 32'h0);
        check("async_rst_mondreg", MonDReg, 32'h0);
        check("async_rst_ready", {31'h0, monitor_ready}, 32'h0);
        check("async_rst_error", {31'h0, monitor_error}, 32'h0);
        check("async_rst_addr", m_address, 32'h0);
        check("async_rst_wdata", m_writedata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        stall_cfg = 0;
        high_cnt = 0;
        repeat (4) @(negedge clk);
        check("post_rst_idle", high_cnt, 0);
        check("post_rst_ready", {31'h0, monitor_ready}, 32'h0);
        $display("reset mid-write m_write=%b ready=%b", m_write, monitor_ready);

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/testcore_nios2_gen2_0_ocimem_master.md
TESTCORE_NIOS2_GEN2_0_OCIMEM_MASTER -- requirements
Module: testcore_nios2_gen2_0_ocimem_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the number of consecutive m_waitrequest cycles before a transfer aborts (legal range 2..65535).
REQ-002 SHALL have port clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-003 SHALL have port reset  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port jdo  in  38  JTAG debug data word from the sysclk-side debug slave.
REQ-005 SHALL have port take_action_ocimem_a  in  1  single-cycle pulse: address/read command.
REQ-006 SHALL have port take_no_action_ocimem_a  in  1  single-cycle pulse: read at the current address.
REQ-007 SHALL have port take_action_ocimem_b  in  1  single-cycle pulse: write command.
REQ-008 SHALL have port MonDReg  out  32  last read data, or last write data.
REQ-009 SHALL have port monitor_ready  out  1  last command completed.
REQ-010 SHALL have port monitor_error  out  1  sticky error flag.
REQ-011 SHALL have Avalon-MM master ports m_address out 32, m_read out 1, m_write out 1, m_writedata out 32, m_byteenable out 4, m_readdata in 32, m_waitrequest in 1.

Function
REQ-012 SHALL implement FSM states IDLE, READ, WRITE; reset state IDLE.
REQ-013 On take_action_ocimem_a in IDLE: addr_reg SHALL load {jdo[31:2],2'b00}, incr_en SHALL load jdo[36], and monitor_error SHALL clear if jdo[34]=1.
- If jdo[35]=1: READ SHALL be entered next cycle and monitor_ready SHALL clear.
- If jdo[35]=0: the FSM SHALL stay in IDLE and monitor_ready SHALL be unchanged.
REQ-014 On take_no_action_ocimem_a in IDLE: READ SHALL be entered at the current addr_reg and monitor_ready SHALL clear.
REQ-015 On take_action_ocimem_b in IDLE: wdata_reg and MonDReg SHALL load jdo[31:0], WRITE SHALL be entered, and monitor_ready SHALL clear.
REQ-016 Command priority, when more than one pulse arrives in the same cycle: take_action_ocimem_a, then take_action_ocimem_b, then take_no_action_ocimem_a; lower-priority pulses SHALL be dropped.
REQ-017 Any command pulse while not in IDLE SHALL be ignored and SHALL set monitor_error.
REQ-018 In READ, m_read SHALL be 1; in WRITE, m_write SHALL be 1; m_address SHALL equal addr_reg, m_writedata SHALL equal wdata_reg, and m_byteenable SHALL be 4'hF.
REQ-019 A transfer SHALL complete on the first cycle with m_waitrequest=0.
- On read completion, MonDReg SHALL capture m_readdata in that same cycle.
- On any completion, monitor_ready SHALL be 1 and the FSM SHALL be in IDLE the next cycle.
REQ-020 On completion with incr_en=1, addr_reg SHALL increase by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 A wait counter SHALL clear on entry to READ/WRITE and SHALL increment each cycle m_waitrequest=1.
- When it reaches TIMEOUT_CYCLES-1 with m_waitrequest still 1, the transfer SHALL abort: monitor_error=1, monitor_ready=1, FSM to IDLE, MonDReg unchanged, addr_reg not incremented.
REQ-022 m_read/m_write SHALL deassert in the cycle after completion/abort and SHALL never be 1 simultaneously.
REQ-023 The minimum command-to-monitor_ready latency SHALL be 2 cycles (pulse cycle + one bus cycle with m_waitrequest=0).

Reset
REQ-024 While reset=1, with no clock required: FSM=IDLE, m_read=0, m_write=0, m_address=0, m_writedata=0, addr_reg=0, incr_en=0, MonDReg=0, monitor_ready=0, monitor_error=0, wait counter=0.
REQ-025 Reset asserted mid-transfer SHALL drop m_read/m_write immediately; the transfer SHALL NOT resume after reset.

Verification
REQ-026 Read: take_action_ocimem_a with jdo[35]=1, jdo[31:0]=32'h0000_1004, m_waitrequest=1 for 3 cycles, m_readdata=32'hDEAD_BEEF -> m_address=32'h1004, m_read high 4 cycles, MonDReg=32'hDEADBEEF, monitor_ready=1.
REQ-027 Write burst: address 32'hFFFF_FFFC with incr_en=1, then two take_action_ocimem_b with data 32'h11/32'h22, m_waitrequest=0 -> writes to 32'hFFFF_FFFC then 32'h0000_0000; addr_reg ends at 32'h4.
REQ-028 Timeout: TIMEOUT_CYCLES=8, read with m_waitrequest held at 1 -> m_read high exactly 8 cycles; monitor_error=1, monitor_ready=1, MonDReg unchanged.
REQ-029 Busy collision: take_action_ocimem_b during READ -> no write issued, monitor_error=1; then take_action_ocimem_a with jdo[34]=1 -> monitor_error=0.
REQ-030 Simultaneous pulses: take_action_ocimem_a (jdo[35]=0) and take_action_ocimem_b in the same cycle -> address loaded, no bus transfer, monitor_ready unchanged.
REQ-031 Reset at cycle 2 of a stalled write -> m_write=0 asynchronously, all outputs at reset values, FSM stays in IDLE after release.
